// File: rtl/cpu_bus_write_ctrl_pkg.sv
// Shared types and default timing constants for the CPU bus write controller.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    CYC_READ,
    CYC_WRITE,
    CYC_HALT
  } cyc_t;

  localparam int CLK_DIV_DEF    = 12;
  localparam int PHI2_START_DEF = 6;
  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 8;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/cpu_bus_write_ctrl_if.sv
// Sequencer-facing request signals and external bus outputs of the write controller.
interface cpu_bus_write_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              wr_req_IN;
  logic [ADDR_W-1:0] wr_addr_IN;
  logic [DATA_W-1:0] wr_data_IN;
  logic              wr_ready_OUT;
  logic [ADDR_W-1:0] rd_addr_IN;
  logic              rdy_IN;
  logic              phi1_OUT;
  logic              phi2_OUT;
  logic              cycle_start_OUT;
  logic [ADDR_W-1:0] addr_OUT;
  logic              rw_OUT;
  logic [DATA_W-1:0] data_OUT;
  logic              data_oe_OUT;
  logic              wr_done_OUT;

  modport slave (
    input  wr_req_IN, wr_addr_IN, wr_data_IN, rd_addr_IN, rdy_IN,
    output wr_ready_OUT, phi1_OUT, phi2_OUT, cycle_start_OUT,
           addr_OUT, rw_OUT, data_OUT, data_oe_OUT, wr_done_OUT
  );

  modport master (
    output wr_req_IN, wr_addr_IN, wr_data_IN, rd_addr_IN, rdy_IN,
    input  wr_ready_OUT, phi1_OUT, phi2_OUT, cycle_start_OUT,
           addr_OUT, rw_OUT, data_OUT, data_oe_OUT, wr_done_OUT
  );
endinterface

// File: rtl/cpu_bus_write_ctrl_fifo.sv
// Two-entry write buffer; slot 0 is always the head, a pop shifts slot 1 down.
module wr_fifo2
  import cpu_bus_pkg::*;
#(
  parameter type entry_t = wr_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  entry_t     wr_entry,
  output entry_t     head,
  output entry_t     second,
  output logic [1:0] level,
  output logic       full,
  output logic       empty
);

  entry_t     slot_q [2];
  logic [1:0] cnt_q;
  logic       push_en, pop_en, wr_idx;

  always_comb begin
    pop_en  = pop && (cnt_q != 2'd0);
    push_en = push && (cnt_q != 2'd2);
    // With one entry and a simultaneous pop the new entry lands in the head slot.
    wr_idx  = (cnt_q == 2'd1) && !pop_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < 2; i++) slot_q[i] <= '0;
    end else begin
      if (pop_en)  slot_q[0] <= slot_q[1];
      if (push_en) slot_q[wr_idx] <= wr_entry;
      cnt_q <= cnt_q + 2'(push_en) - 2'(pop_en);
    end
  end

  assign head   = slot_q[0];
  assign second = slot_q[1];
  assign level  = cnt_q;
  assign full   = (cnt_q == 2'd2);
  assign empty  = (cnt_q == 2'd0);

endmodule

// File: rtl/cpu_bus_write_ctrl.sv
// Generates phi1/phi2, sequences CPU bus cycles and issues buffered writes or reads.
module cpu_bus_write_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int PHI2_START = PHI2_START_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input logic clk,
  input logic reset,
  cpu_bus_write_ctrl_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_entry_t;

  localparam int            PW   = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P2   = PW'(PHI2_START);

  logic [PW-1:0]     phase_q, phase_d;
  cyc_t              cyc_q, cyc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d, oe_q, oe_d;
  logic              phi1_q, phi2_q, phi2_d, cs_q, cs_d;
  logic              done_q, done_d, ready_q, ready_d;
  logic              push, pop, full, empty;
  logic [1:0]        level;
  bus_entry_t        wr_in, head, second;

  assign wr_in.addr = bus.wr_addr_IN;
  assign wr_in.data = bus.wr_data_IN;
  assign push = bus.wr_req_IN && ready_q;
  assign pop  = (cyc_q == CYC_WRITE) && (phase_q == LAST);

  wr_fifo2 #(.entry_t(bus_entry_t)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_in),
    .head     (head),
    .second   (second),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    if (phase_q == LAST) begin
      // Head after this edge's pop; an entry pushed on this edge is not yet eligible.
      if (!empty && (!pop || full)) begin
        cyc_d  = CYC_WRITE;
        addr_d = pop ? second.addr : head.addr;
        data_d = pop ? second.data : head.data;
        rw_d   = 1'b0;
      end else if (!bus.rdy_IN) begin
        cyc_d = CYC_HALT;
        rw_d  = 1'b1;
      end else begin
        cyc_d  = CYC_READ;
        addr_d = bus.rd_addr_IN;
        rw_d   = 1'b1;
      end
    end
    phi2_d  = (phase_d >= P2);
    cs_d    = (phase_d == '0);
    oe_d    = (cyc_d == CYC_WRITE) && phi2_d;
    done_d  = pop;
    ready_d = pop || !(full || (push && level == 2'd1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      cyc_q   <= CYC_READ;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b1;
      oe_q    <= 1'b0;
      phi2_q  <= 1'b0;
      phi1_q  <= 1'b1;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      phi2_q  <= phi2_d;
      phi1_q  <= ~phi2_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.phi1_OUT        = phi1_q;
  assign bus.phi2_OUT        = phi2_q;
  assign bus.cycle_start_OUT = cs_q;
  assign bus.addr_OUT        = addr_q;
  assign bus.rw_OUT          = rw_q;
  assign bus.data_OUT        = data_q;
  assign bus.data_oe_OUT     = oe_q;
  assign bus.wr_done_OUT     = done_q;
  assign bus.wr_ready_OUT    = ready_q;

endmodule

// File: tb/tb_cpu_bus_write_ctrl.sv
// Self-checking bench: cycle model with a scoreboard queue of accepted writes.
module tb_cpu_bus_write_ctrl;
  import cpu_bus_pkg::*;

  localparam int CLK_DIV    = 12;
  localparam int PHI2_START = 6;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;

  logic clk = 1'b0;
  logic reset;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cpu_bus_write_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cpu_bus_write_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .PHI2_START(PHI2_START),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t              sb[$];
  int                e_phase;
  cyc_t              e_cyc;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  logic              e_rw, e_done, e_ready, m_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected bus state after each edge; accepted writes queue up in sb.
  always @(posedge clk) begin
    if (reset) begin
      e_phase = 0;
      e_cyc   = CYC_READ;
      e_addr  = '0;
      e_data  = '0;
      e_rw    = 1'b1;
      e_done  = 1'b0;
      e_ready = 1'b0;
      sb.delete();
    end else begin
      m_acc  = bus.wr_req_IN && e_ready;
      e_done = 1'b0;
      if (e_phase == CLK_DIV - 1) begin
        if (e_cyc == CYC_WRITE && sb.size() > 0) begin
          sb.delete(0);
          e_done = 1'b1;
        end
        if (sb.size() > 0) begin
          e_cyc  = CYC_WRITE;
          e_addr = sb[0].a;
          e_data = sb[0].d;
          e_rw   = 1'b0;
        end else if (!bus.rdy_IN) begin
          e_cyc = CYC_HALT;
          e_rw  = 1'b1;
        end else begin
          e_cyc  = CYC_READ;
          e_addr = bus.rd_addr_IN;
          e_rw   = 1'b1;
        end
        e_phase = 0;
      end else begin
        e_phase++;
      end
      if (m_acc) sb.push_back('{bus.wr_addr_IN, bus.wr_data_IN});
      e_ready = (sb.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("phi2",        32'(bus.phi2_OUT),        32'(e_phase >= PHI2_START));
      chk("phi1",        32'(bus.phi1_OUT),        32'(e_phase < PHI2_START));
      chk("cycle_start", 32'(bus.cycle_start_OUT), 32'(e_phase == 0));
      chk("addr",        32'(bus.addr_OUT),        32'(e_addr));
      chk("rw",          32'(bus.rw_OUT),          32'(e_rw));
      chk("data",        32'(bus.data_OUT),        32'(e_data));
      chk("data_oe",     32'(bus.data_oe_OUT),     32'(e_cyc == CYC_WRITE && e_phase >= PHI2_START));
      chk("wr_done",     32'(bus.wr_done_OUT),     32'(e_done));
      chk("wr_ready",    32'(bus.wr_ready_OUT),    32'(e_ready));
    end
  end

  task automatic wait_phase(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (e_phase != k && n < 2 * CLK_DIV);
    if (e_phase != k) chk("wait_phase", 32'(e_phase), 32'(k));
  endtask

  task automatic drive_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wr_req_IN  = 1'b1;
    bus.wr_addr_IN = a;
    bus.wr_data_IN = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.wr_req_IN  = 1'b0;
    bus.wr_addr_IN = '0;
    bus.wr_data_IN = '0;
    bus.rd_addr_IN = 16'hC000;
    bus.rdy_IN     = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rw",    32'(bus.rw_OUT),       32'd1);
    chk("rst_oe",    32'(bus.data_oe_OUT),  32'd0);
    chk("rst_ready", 32'(bus.wr_ready_OUT), 32'd0);
    chk("rst_phi1",  32'(bus.phi1_OUT),     32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t1_ready", 32'(bus.wr_ready_OUT), 32'd1);

    // 1: plain read cycles
    wait_phase(0);
    chk("t1_addr", 32'(bus.addr_OUT), 32'hC000);
    chk("t1_rw",   32'(bus.rw_OUT),   32'd1);
    wait_phase(6);
    chk("t1_phi2", 32'(bus.phi2_OUT), 32'd1);

    // 2: single write accepted in phase 3
    wait_phase(3);
    drive_req(16'h2006, 8'h3F);
    @(negedge clk);
    bus.wr_req_IN = 1'b0;
    wait_phase(0);
    chk("t2_rw",   32'(bus.rw_OUT),      32'd0);
    chk("t2_addr", 32'(bus.addr_OUT),    32'h2006);
    chk("t2_data", 32'(bus.data_OUT),    32'h3F);
    wait_phase(5);
    chk("t2_oe5",  32'(bus.data_oe_OUT), 32'd0);
    wait_phase(6);
    chk("t2_oe6",  32'(bus.data_oe_OUT), 32'd1);
    wait_phase(0);
    chk("t2_done", 32'(bus.wr_done_OUT), 32'd1);
    chk("t2_rd",   32'(bus.addr_OUT),    32'hC000);

    // 3: three back-to-back requests, third refused
    wait_phase(2);
    drive_req(16'h3003, 8'h11);
    @(negedge clk);
    chk("t3_ready_b", 32'(bus.wr_ready_OUT), 32'd1);
    drive_req(16'h3103, 8'h22);
    @(negedge clk);
    chk("t3_ready_c", 32'(bus.wr_ready_OUT), 32'd0);
    drive_req(16'h3203, 8'h33);
    @(negedge clk);
    bus.wr_req_IN = 1'b0;
    wait_phase(0);
    chk("t3_a_addr", 32'(bus.addr_OUT), 32'h3003);
    chk("t3_a_rw",   32'(bus.rw_OUT),   32'd0);
    wait_phase(0);
    chk("t3_b_addr", 32'(bus.addr_OUT),     32'h3103);
    chk("t3_b_data", 32'(bus.data_OUT),     32'h22);
    chk("t3_ready",  32'(bus.wr_ready_OUT), 32'd1);
    wait_phase(0);
    chk("t3_rw_end", 32'(bus.rw_OUT), 32'd1);

    // 4: RDY low holds address; a write still proceeds
    bus.rd_addr_IN = 16'h8000;
    wait_phase(0);
    chk("t4_addr", 32'(bus.addr_OUT), 32'h8000);
    wait_phase(1);
    bus.rdy_IN     = 1'b0;
    bus.rd_addr_IN = 16'h9000;
    wait_phase(0);
    chk("t4_halt_addr", 32'(bus.addr_OUT), 32'h8000);
    chk("t4_halt_rw",   32'(bus.rw_OUT),   32'd1);
    wait_phase(4);
    drive_req(16'h4004, 8'h55);
    @(negedge clk);
    bus.wr_req_IN = 1'b0;
    wait_phase(0);
    chk("t4_wr_addr", 32'(bus.addr_OUT), 32'h4004);
    chk("t4_wr_rw",   32'(bus.rw_OUT),   32'd0);
    wait_phase(0);
    chk("t4_hold", 32'(bus.addr_OUT), 32'h4004);
    wait_phase(1);
    bus.rdy_IN = 1'b1;
    wait_phase(0);
    chk("t4_resume", 32'(bus.addr_OUT), 32'h9000);

    // 5: write accepted on the phase-0 edge waits one extra cycle
    wait_phase(11);
    drive_req(16'h5005, 8'hA5);
    wait_phase(0);
    bus.wr_req_IN = 1'b0;
    chk("t5_rd_rw", 32'(bus.rw_OUT), 32'd1);
    wait_phase(0);
    chk("t5_wr_addr", 32'(bus.addr_OUT), 32'h5005);
    chk("t5_wr_rw",   32'(bus.rw_OUT),   32'd0);

    // 6: reset in the middle of a write
    wait_phase(3);
    drive_req(16'h6006, 8'h66);
    @(negedge clk);
    bus.wr_req_IN = 1'b0;
    wait_phase(0);
    chk("t6_rw", 32'(bus.rw_OUT), 32'd0);
    wait_phase(8);
    chk("t6_oe", 32'(bus.data_oe_OUT), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_oe", 32'(bus.data_oe_OUT), 32'd0);
    chk("t6_rst_rw", 32'(bus.rw_OUT),      32'd1);
    @(negedge clk);
    reset = 1'b0;
    wait_phase(0);
    chk("t6_no_done", 32'(bus.wr_done_OUT), 32'd0);
    chk("t6_read",    32'(bus.rw_OUT),      32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.wr_req_IN  = ($urandom_range(0, 3) == 0);
      bus.wr_addr_IN = ADDR_W'($urandom);
      bus.wr_data_IN = DATA_W'($urandom);
      bus.rdy_IN     = ($urandom_range(0, 3) != 0);
      if (i % 13 == 0) bus.rd_addr_IN = ADDR_W'($urandom);
    end
    bus.wr_req_IN = 1'b0;
    bus.rdy_IN    = 1'b1;
    repeat (4 * CLK_DIV) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
